// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: synchronizes hsync/vsync, measures line/frame timing and
// tracks lock across consecutive frames with matching geometry.
module vga_sync_decoder #(
  parameter int H_W         = 12,
  parameter int V_W         = 11,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hsync,
  input  logic           vsync,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic [H_W-1:0] h_total,
  output logic [H_W-1:0] hs_width,
  output logic [V_W-1:0] v_total,
  output logic [V_W-1:0] vs_width,
  output logic           locked,
  output logic           frame_start,
  output logic           err
);

  localparam logic [H_W-1:0] H_MAX    = '1;
  localparam logic [V_W-1:0] V_MAX    = '1;
  localparam logic [3:0]     LOCK_TGT = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  function automatic logic [H_W-1:0] h_inc(input logic [H_W-1:0] v);
    return (v == H_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [V_W-1:0] v_inc(input logic [V_W-1:0] v);
    return (v == V_MAX) ? v : v + 1'b1;
  endfunction

  logic hs_p0, hs_p1, hs_p2, vs_p0, vs_p1, vs_p2;
  logic [H_W-1:0] h_cnt, hs_wcnt, ref_h, ref_h_d, h_len, h_new;
  logic [V_W-1:0] v_cnt, vs_wcnt, ref_v, ref_v_d, v_len, v_new;
  logic [3:0] match_cnt, match_cnt_d;
  logic line_bad, skip_chk, bad_now, match, err_d;
  logic hs_act, hs_lead, hs_trail, vs_act, vs_lead, vs_trail;
  logic h_to_evt, v_to_evt, cnt_sat;
  state_t state_q, state_d;

  // Stage p0/p1: two-flop synchronizers; p2: delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p0 <= ~HS_POL; hs_p1 <= ~HS_POL; hs_p2 <= ~HS_POL;
      vs_p0 <= ~VS_POL; vs_p1 <= ~VS_POL; vs_p2 <= ~VS_POL;
    end else begin
      hs_p0 <= hsync; hs_p1 <= hs_p0; hs_p2 <= hs_p1;
      vs_p0 <= vsync; vs_p1 <= vs_p0; vs_p2 <= vs_p1;
    end
  end

  always_comb begin
    hs_act   = (hs_p1 == HS_POL);
    hs_lead  = hs_act && (hs_p2 != HS_POL);
    hs_trail = !hs_act && (hs_p2 == HS_POL);
    vs_act   = (vs_p1 == VS_POL);
    vs_lead  = vs_act && (vs_p2 != VS_POL);
    vs_trail = !vs_act && (vs_p2 == VS_POL);
    h_len    = h_inc(h_cnt);
    v_len    = v_inc(v_cnt);
    h_new    = hs_lead ? h_len : h_total;
    v_new    = hs_lead ? v_len : v_cnt;
    bad_now  = line_bad || (hs_lead && !skip_chk && (h_len != h_total));
    match    = (h_new == ref_h) && (v_new == ref_v) && !bad_now;
    h_to_evt = !hs_lead && (h_len == H_MAX) && (h_cnt != H_MAX);
    v_to_evt = hs_lead && !vs_lead && (v_len == V_MAX) && (v_cnt != V_MAX);
    cnt_sat  = (h_cnt == H_MAX) || (v_cnt == V_MAX);
  end

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt;
    ref_h_d     = ref_h;
    ref_v_d     = ref_v;
    err_d       = 1'b0;
    if (h_to_evt || v_to_evt) begin
      state_d     = SEARCH;
      match_cnt_d = '0;
      err_d       = 1'b1;
    end else if (cnt_sat) begin
      state_d     = SEARCH;
      match_cnt_d = '0;
    end else if (vs_lead) begin
      unique case (state_q)
        SEARCH: begin
          ref_h_d     = h_new;
          ref_v_d     = v_new;
          match_cnt_d = '0;
          state_d     = VERIFY;
        end
        VERIFY: begin
          if (match) begin
            match_cnt_d = match_cnt + 1'b1;
            if (match_cnt + 1'b1 == LOCK_TGT) state_d = LOCKED;
          end else begin
            ref_h_d     = h_new;
            ref_v_d     = v_new;
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            ref_h_d     = h_new;
            ref_v_d     = v_new;
            match_cnt_d = '0;
            state_d     = VERIFY;
            err_d       = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Stage p3: edge handling updates counters, measurements and lock state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0; h_total <= '0; hs_wcnt <= '0; hs_width <= '0;
      v_cnt <= '0; v_total <= '0; vs_wcnt <= '0; vs_width <= '0;
      ref_h <= '0; ref_v <= '0; match_cnt <= '0;
      line_bad <= 1'b0; skip_chk <= 1'b1;
      frame_start <= 1'b0; err <= 1'b0;
      state_q <= SEARCH;
    end else begin
      h_cnt    <= hs_lead ? '0 : h_len;
      hs_wcnt  <= hs_act ? h_inc(hs_wcnt) : '0;
      vs_wcnt  <= !vs_act ? '0 : (hs_lead ? v_inc(vs_wcnt) : vs_wcnt);
      if (hs_lead) h_total <= h_len;
      if (hs_trail) hs_width <= hs_wcnt;
      if (vs_trail) vs_width <= vs_wcnt;
      if (vs_lead) begin
        v_total <= v_new;
        v_cnt   <= '0;
      end else if (hs_lead) begin
        v_cnt <= v_len;
      end
      // The first line after SEARCH compares against a stale h_total
      if (state_q == SEARCH) skip_chk <= 1'b1;
      else if (hs_lead) skip_chk <= 1'b0;
      line_bad    <= vs_lead ? 1'b0 : bad_now;
      ref_h       <= ref_h_d;
      ref_v       <= ref_v_d;
      match_cnt   <= match_cnt_d;
      state_q     <= state_d;
      frame_start <= vs_lead;
      err         <= err_d;
    end
  end

  assign x      = h_cnt;
  assign y      = v_cnt;
  assign locked = (state_q == LOCKED);

endmodule
